// File: rtl/cpm_pkg.sv
// Shared types and width defaults for the CPM count/enable strobe path.
package cpm_pkg;

    localparam int CPM_CNT_DW = 8;
    localparam int CPM_GAP_GW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } cpm_state_e;

    typedef struct packed {
        logic [CPM_CNT_DW-1:0] cnt;
        logic [CPM_GAP_GW-1:0] gap;
    } cpm_cmd_t;

endpackage

// File: rtl/cpm_cnt_burst_gen_if.sv
// Command and strobe signals between the sequencer, the burst generator and a CPM counter.
interface cpm_cnt_burst_gen_if
    import cpm_pkg::*;
#(
    parameter int DW = CPM_CNT_DW,
    parameter int GW = CPM_GAP_GW
);

    logic          clear;
    logic          cmd_vld;
    logic          cmd_rdy;
    logic [DW-1:0] cmd_cnt;
    logic [GW-1:0] cmd_gap;
    logic          out_en;
    logic          out_rdy;
    logic [DW-1:0] out_idx;
    logic          out_last;
    logic [DW-1:0] remain;
    logic          busy;
    logic          done;

    // The generator side produces strobes and status.
    modport master (
        input  clear,
        input  cmd_vld,
        input  cmd_cnt,
        input  cmd_gap,
        input  out_rdy,
        output cmd_rdy,
        output out_en,
        output out_idx,
        output out_last,
        output remain,
        output busy,
        output done
    );

    modport slave (
        output clear,
        output cmd_vld,
        output cmd_cnt,
        output cmd_gap,
        output out_rdy,
        input  cmd_rdy,
        input  out_en,
        input  out_idx,
        input  out_last,
        input  remain,
        input  busy,
        input  done
    );

endinterface

// File: rtl/cpm_cnt_burst_gen_fifo2.sv
// Two-entry register FIFO holding queued count commands; flush empties it in one cycle.
module cpm_cmd_fifo2
    import cpm_pkg::*;
#(
    parameter type T = cpm_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  T     wr_data,
    output T     rd_data,
    output logic full,
    output logic empty
);

    T           mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // Payload storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cpm_cnt_burst_gen.sv
// Emits exactly N enable strobes per queued command, with a programmable idle gap and back-pressure.
module cpm_cnt_burst_gen
    import cpm_pkg::*;
#(
    parameter int DW = CPM_CNT_DW,
    parameter int GW = CPM_GAP_GW
) (
    input  logic                 clk,
    input  logic                 rst,
    cpm_cnt_burst_gen_if.master  bus
);

    typedef struct packed {
        logic [DW-1:0] cnt;
        logic [GW-1:0] gap;
    } cmd_t;

    cmd_t          push_cmd;
    cmd_t          head;
    logic          full;
    logic          empty;
    logic          cmd_rdy;
    logic          push;
    logic          pop;
    logic          out_en;
    logic          done;

    cpm_state_e    state;
    cpm_state_e    state_nxt;
    logic [DW-1:0] rem;
    logic [DW-1:0] rem_nxt;
    logic [DW-1:0] idx;
    logic [DW-1:0] idx_nxt;
    logic [GW-1:0] gap_r;
    logic [GW-1:0] gap_nxt;
    logic [GW-1:0] gcnt;
    logic [GW-1:0] gcnt_nxt;

    // Ready looks only at the pre-pop occupancy, so there is no path from pop to cmd_rdy.
    assign cmd_rdy      = ~full & ~bus.clear;
    assign push         = bus.cmd_vld & cmd_rdy;
    assign push_cmd.cnt = bus.cmd_cnt;
    assign push_cmd.gap = bus.cmd_gap;

    cpm_cmd_fifo2 #(
        .T (cmd_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.clear),
        .push    (push),
        .pop     (pop),
        .wr_data (push_cmd),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rem   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk) begin
        gap_r <= gap_nxt;
        gcnt  <= gcnt_nxt;
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        idx_nxt   = idx;
        gap_nxt   = gap_r;
        gcnt_nxt  = gcnt;
        pop       = 1'b0;
        out_en    = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    rem_nxt   = head.cnt;
                    idx_nxt   = '0;
                    gap_nxt   = head.gap;
                    state_nxt = (head.cnt != '0) ? EMIT : DONE;
                end
            end
            EMIT: begin
                out_en = 1'b1;
                if (bus.out_rdy) begin
                    idx_nxt = idx + DW'(1);
                    rem_nxt = rem - DW'(1);
                    if (rem == DW'(1)) begin
                        state_nxt = DONE;
                    end else if (gap_r != '0) begin
                        state_nxt = GAP;
                        gcnt_nxt  = gap_r;
                    end
                end
            end
            GAP: begin
                gcnt_nxt = gcnt - GW'(1);
                if (gcnt == GW'(1)) state_nxt = EMIT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over everything; a strobe handshaked this cycle is still delivered.
        if (bus.clear) begin
            state_nxt = IDLE;
            rem_nxt   = '0;
            idx_nxt   = '0;
            pop       = 1'b0;
        end
    end

    assign bus.cmd_rdy  = cmd_rdy;
    assign bus.out_en   = out_en;
    assign bus.out_idx  = idx;
    assign bus.out_last = out_en & (rem == DW'(1));
    assign bus.remain   = rem;
    assign bus.busy     = (state != IDLE) | ~empty;
    assign bus.done     = done;

endmodule

// File: tb/tb_cpm_cnt_burst_gen.sv
// Directed bench for the CPM strobe generator with hand-derived expectations.
module tb_cpm_cnt_burst_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mon_clr = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs;
    int   dn;

    always #5 clk = ~clk;

    cpm_cnt_burst_gen_if #(.DW(8), .GW(4)) bus ();

    cpm_cnt_burst_gen #(.DW(8), .GW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Downstream event counter fed by the strobes, plus a Done pulse counter.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs <= 0;
            dn <= 0;
        end else if (mon_clr) begin
            hs <= 0;
            dn <= 0;
        end else begin
            if (bus.out_en && bus.out_rdy) hs <= hs + 1;
            if (bus.done) dn <= dn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.cmd_vld = 1'b0;
        bus.cmd_cnt = '0;
        bus.cmd_gap = '0;
        bus.out_rdy = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 1);
        chk("rst_out_en", 32'(bus.out_en), 0);
        chk("rst_out_idx", 32'(bus.out_idx), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_remain", 32'(bus.remain), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        step();

        // Cnt=5, Gap=0: five back-to-back strobes
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd5; bus.cmd_gap = 4'd0;
        step();
        bus.cmd_vld = 1'b0;
        chk("t1_busy_queued", 32'(bus.busy), 1);
        chk("t1_en_before_pop", 32'(bus.out_en), 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("t1_en", 32'(bus.out_en), 1);
            chk("t1_idx", 32'(bus.out_idx), 32'(i));
            chk("t1_last", 32'(bus.out_last), (i == 4) ? 1 : 0);
            chk("t1_remain", 32'(bus.remain), 32'(5 - i));
            step();
        end
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_en_off", 32'(bus.out_en), 0);
        chk("t1_counter", 32'(hs), 5);
        step();
        chk("t1_done_pulse", 32'(bus.done), 0);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_idle_remain", 32'(bus.remain), 0);

        // Cnt=3, Gap=2: pattern 1,0,0,1,0,0,1
        clr_mon();
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd3; bus.cmd_gap = 4'd2;
        step();
        bus.cmd_vld = 1'b0;
        step();
        begin
            logic [6:0] pat;
            int         rem_exp [7];
            pat = 7'b1001001;
            rem_exp = '{3, 2, 2, 2, 1, 1, 1};
            for (int i = 0; i < 7; i++) begin
                chk("t2_en", 32'(bus.out_en), 32'(pat[6 - i]));
                chk("t2_remain", 32'(bus.remain), 32'(rem_exp[i]));
                step();
            end
        end
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_counter", 32'(hs), 3);
        step();

        // Cnt=4 with three stalled cycles at idx 1
        clr_mon();
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd4; bus.cmd_gap = 4'd0;
        step();
        bus.cmd_vld = 1'b0;
        step();
        chk("t3_idx0", 32'(bus.out_idx), 0);
        step();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_en", 32'(bus.out_en), 1);
            chk("t3_stall_idx", 32'(bus.out_idx), 1);
            chk("t3_stall_remain", 32'(bus.remain), 3);
            chk("t3_stall_last", 32'(bus.out_last), 0);
            step();
        end
        bus.out_rdy = 1'b1;
        chk("t3_resume_idx", 32'(bus.out_idx), 1);
        step();
        chk("t3_idx2", 32'(bus.out_idx), 2);
        step();
        chk("t3_idx3_last", 32'(bus.out_last), 1);
        step();
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_counter", 32'(hs), 4);
        step();

        // Back-to-back commands Cnt=2, Cnt=0, Cnt=1
        clr_mon();
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd2; bus.cmd_gap = 4'd0;
        chk("t4_rdy_push1", 32'(bus.cmd_rdy), 1);
        step();
        bus.cmd_cnt = 8'd0;
        chk("t4_rdy_push2", 32'(bus.cmd_rdy), 1);
        step();
        bus.cmd_cnt = 8'd1;
        chk("t4_rdy_push3", 32'(bus.cmd_rdy), 1);
        chk("t4_a_idx0", 32'(bus.out_idx), 0);
        chk("t4_a_en0", 32'(bus.out_en), 1);
        step();
        bus.cmd_vld = 1'b0;
        chk("t4_rdy_full", 32'(bus.cmd_rdy), 0);
        chk("t4_a_idx1", 32'(bus.out_idx), 1);
        chk("t4_a_last", 32'(bus.out_last), 1);
        step();
        chk("t4_a_done", 32'(bus.done), 1);
        step();
        chk("t4_idle_rdy_prepop", 32'(bus.cmd_rdy), 0);
        chk("t4_idle_busy", 32'(bus.busy), 1);
        step();
        chk("t4_b_done", 32'(bus.done), 1);
        chk("t4_b_no_strobe", 32'(bus.out_en), 0);
        chk("t4_rdy_after_pop", 32'(bus.cmd_rdy), 1);
        step();
        step();
        chk("t4_c_idx0", 32'(bus.out_idx), 0);
        chk("t4_c_last", 32'(bus.out_last), 1);
        step();
        chk("t4_c_done", 32'(bus.done), 1);
        step();
        chk("t4_busy_end", 32'(bus.busy), 0);
        chk("t4_strobes", 32'(hs), 3);
        chk("t4_done_pulses", 32'(dn), 3);

        // Clear during Cnt=10 at idx 4 with one command queued
        clr_mon();
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd10; bus.cmd_gap = 4'd0;
        step();
        bus.cmd_cnt = 8'd1;
        step();
        bus.cmd_vld = 1'b0;
        repeat (4) step();
        chk("t5_idx4", 32'(bus.out_idx), 4);
        bus.clear = 1'b1;
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd7;
        #1;
        chk("t5_rdy_in_clear", 32'(bus.cmd_rdy), 0);
        step();
        bus.clear = 1'b0;
        bus.cmd_vld = 1'b0;
        chk("t5_en_off", 32'(bus.out_en), 0);
        chk("t5_busy_off", 32'(bus.busy), 0);
        chk("t5_remain_zero", 32'(bus.remain), 0);
        chk("t5_no_done", 32'(bus.done), 0);
        chk("t5_delivered", 32'(hs), 5);
        step();
        chk("t5_queue_lost", 32'(bus.busy), 0);
        chk("t5_no_done_late", 32'(dn), 0);
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd1; bus.cmd_gap = 4'd0;
        step();
        bus.cmd_vld = 1'b0;
        step();
        chk("t5_new_en", 32'(bus.out_en), 1);
        chk("t5_new_last", 32'(bus.out_last), 1);
        step();
        chk("t5_new_done", 32'(bus.done), 1);
        step();

        // Rst asserted mid-GAP
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd3; bus.cmd_gap = 4'd3;
        step();
        bus.cmd_vld = 1'b0;
        step();
        chk("t6_en", 32'(bus.out_en), 1);
        step();
        chk("t6_gap_en", 32'(bus.out_en), 0);
        chk("t6_gap_remain", 32'(bus.remain), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_remain", 32'(bus.remain), 0);
        chk("t6_rst_idx", 32'(bus.out_idx), 0);
        chk("t6_rst_en", 32'(bus.out_en), 0);
        chk("t6_rst_rdy", 32'(bus.cmd_rdy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("t6_post_rdy", 32'(bus.cmd_rdy), 1);
        chk("t6_post_busy", 32'(bus.busy), 0);

        // Cnt=255, Gap=0: full-range count without wrap
        clr_mon();
        bus.cmd_vld = 1'b1; bus.cmd_cnt = 8'd255; bus.cmd_gap = 4'd0;
        step();
        bus.cmd_vld = 1'b0;
        step();
        for (int i = 0; i < 255; i++) begin
            chk("t7_en", 32'(bus.out_en), 1);
            chk("t7_remain", 32'(bus.remain), 32'(255 - i));
            chk("t7_idx", 32'(bus.out_idx), 32'(i));
            step();
        end
        chk("t7_done", 32'(bus.done), 1);
        chk("t7_counter", 32'(hs), 255);
        chk("t7_remain_end", 32'(bus.remain), 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
